// File: rtl/gmii_tx_speed_adapter.sv
// Byte-stream to GMII/MII transmit adapter: paces bytes (1G) or nibbles (100M, 1-in-5 strobe),
// switches speed only between frames and forces an inter-frame gap after every frame.
module gmii_tx_speed_adapter #(
  parameter int IPG_BYTES   = 12,
  parameter int CE_DIV_100M = 5
) (
  input  logic       tx_clk,
  input  logic       rst_n,
  input  logic       is_1g,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] gtxd,
  output logic       gtx_en,
  output logic       gtx_ce,
  output logic       tx_underrun,
  output logic       busy
);

  localparam int IW = $clog2(2*IPG_BYTES+1);
  localparam logic [2:0]    DIV_END      = 3'(CE_DIV_100M-1);
  localparam logic [IW-1:0] IPG_END_1G   = IW'(IPG_BYTES-1);
  localparam logic [IW-1:0] IPG_END_100M = IW'(2*IPG_BYTES-1);

  typedef enum logic [1:0] {IDLE, DATA, IPG} state_t;

  state_t        state_q, state_d;
  logic          spd_meta_q, spd_meta_d, spd_s_q, spd_s_d;
  logic          mode_q, mode_d;
  logic [2:0]    div_cnt_q, div_cnt_d;
  logic [IW-1:0] ipg_cnt_q, ipg_cnt_d;
  logic [7:0]    buf_q, buf_d;
  logic          last_q, last_d;
  logic          phase_q, phase_d;
  logic          fin_q, fin_d;
  logic          uf_q, uf_d;
  logic [7:0]    gtxd_q, gtxd_d;
  logic          gtx_en_q, gtx_en_d;
  logic          gtx_ce_q, gtx_ce_d;
  logic          tx_underrun_q, tx_underrun_d;
  logic          tick, hs, end_frame, end_uf;

  always_comb begin
    tick = mode_q | (div_cnt_q == DIV_END);
    unique case (state_q)
      IDLE:    s_ready = tick;
      DATA:    s_ready = mode_q ? ~last_q : (tick & phase_q & ~last_q);
      default: s_ready = 1'b0;
    endcase
    hs = s_valid & s_ready;
  end

  always_comb begin
    state_d       = state_q;
    spd_meta_d    = is_1g;
    spd_s_d       = spd_meta_q;
    mode_d        = mode_q;
    ipg_cnt_d     = ipg_cnt_q;
    buf_d         = buf_q;
    last_d        = last_q;
    phase_d       = phase_q;
    fin_d         = fin_q;
    uf_d          = uf_q;
    gtxd_d        = gtxd_q;
    gtx_en_d      = gtx_en_q;
    gtx_ce_d      = tick;
    tx_underrun_d = 1'b0;
    end_frame     = 1'b0;
    end_uf        = 1'b0;

    // Speed may only follow the synchronizer while idle and not starting a frame this cycle.
    if (state_q == IDLE && !hs) mode_d = spd_s_q;

    if (mode_d != mode_q || mode_q || tick) div_cnt_d = 3'd0;
    else                                    div_cnt_d = div_cnt_q + 3'd1;

    unique case (state_q)
      IDLE: begin
        if (hs) begin
          state_d  = DATA;
          buf_d    = s_data;
          last_d   = s_last;
          phase_d  = 1'b1;
          fin_d    = 1'b0;
          uf_d     = 1'b0;
          gtx_en_d = 1'b1;
          gtxd_d   = mode_q ? s_data : {4'h0, s_data[3:0]};
        end
      end
      DATA: begin
        if (tick) begin
          if (mode_q) begin
            if (last_q || !s_valid) begin
              end_frame = 1'b1;
              end_uf    = ~last_q;
            end else begin
              gtxd_d = s_data;
              last_d = s_last;
            end
          end else if (phase_q) begin
            // High-nibble slot doubles as the fetch slot for the next byte.
            gtxd_d  = {4'h0, buf_q[7:4]};
            phase_d = 1'b0;
            if (last_q)       fin_d = 1'b1;
            else if (s_valid) begin
              buf_d  = s_data;
              last_d = s_last;
            end else          uf_d = 1'b1;
          end else begin
            if (fin_q || uf_q) begin
              end_frame = 1'b1;
              end_uf    = uf_q;
            end else begin
              gtxd_d  = {4'h0, buf_q[3:0]};
              phase_d = 1'b1;
            end
          end
        end
      end
      IPG: begin
        if (tick) begin
          if (ipg_cnt_q == (mode_q ? IPG_END_1G : IPG_END_100M)) begin
            state_d   = IDLE;
            ipg_cnt_d = '0;
          end else begin
            ipg_cnt_d = ipg_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (end_frame) begin
      state_d       = IPG;
      ipg_cnt_d     = '0;
      gtx_en_d      = 1'b0;
      gtxd_d        = 8'h00;
      tx_underrun_d = end_uf;
    end
  end

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      spd_meta_q    <= 1'b0;
      spd_s_q       <= 1'b0;
      mode_q        <= 1'b0;
      div_cnt_q     <= 3'd0;
      ipg_cnt_q     <= '0;
      buf_q         <= 8'h00;
      last_q        <= 1'b0;
      phase_q       <= 1'b0;
      fin_q         <= 1'b0;
      uf_q          <= 1'b0;
      gtxd_q        <= 8'h00;
      gtx_en_q      <= 1'b0;
      gtx_ce_q      <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      spd_meta_q    <= spd_meta_d;
      spd_s_q       <= spd_s_d;
      mode_q        <= mode_d;
      div_cnt_q     <= div_cnt_d;
      ipg_cnt_q     <= ipg_cnt_d;
      buf_q         <= buf_d;
      last_q        <= last_d;
      phase_q       <= phase_d;
      fin_q         <= fin_d;
      uf_q          <= uf_d;
      gtxd_q        <= gtxd_d;
      gtx_en_q      <= gtx_en_d;
      gtx_ce_q      <= gtx_ce_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign gtxd        = gtxd_q;
  assign gtx_en      = gtx_en_q;
  assign gtx_ce      = gtx_ce_q;
  assign tx_underrun = tx_underrun_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_gmii_tx_speed_adapter.sv
// Randomized + directed bench: frames reassembled from the pin side are scored against the
// bytes handed in, with slot pacing, enable length, gap and underrun rules checked per frame.
module tb_gmii_tx_speed_adapter;

  logic       tx_clk = 1'b0;
  logic       rst_n, is_1g, s_valid, s_last;
  logic [7:0] s_data;
  logic       s_ready, gtx_en, gtx_ce, tx_underrun, busy;
  logic [7:0] gtxd;

  gmii_tx_speed_adapter dut (
    .tx_clk(tx_clk), .rst_n(rst_n), .is_1g(is_1g),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .gtxd(gtxd), .gtx_en(gtx_en), .gtx_ce(gtx_ce), .tx_underrun(tx_underrun), .busy(busy)
  );

  always #4 tx_clk = ~tx_clk;

  int errs = 0, nchk = 0;
  int ucnt = 0, n_cut = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state: what the pins must carry, in order
  logic [7:0] exp_bytes[$];
  int         exp_len[$];
  bit         exp_mode_q[$];
  bit         exp_uf_q[$];
  logic [7:0] fb[64];
  bit         mon_off = 1'b0;
  bit         chk_lat = 1'b0;
  longint     hs_t;

  // ---------------- monitor ----------------
  longint     t, fall_t, rise_t, last_ce_t;
  int         nrx, nib_i, min_gap, n_exp;
  bit         cur_mode, have_nib, gap_armed, ipg_armed, prev_en, prev_busy, uf_e;
  logic [3:0] lo;

  task automatic take(input logic [7:0] b);
    if (exp_bytes.size() == 0) chk("extra_byte", 32'(b), 32'hFFFF);
    else chk("data", 32'(b), 32'(exp_bytes.pop_front()));
    nrx++;
  endtask

  always @(negedge tx_clk) begin
    t = $time;
    if (!rst_n || mon_off) begin
      prev_en = 0; prev_busy = 0; gap_armed = 0; ipg_armed = 0;
    end else begin
      if (tx_underrun) ucnt++;
      if (gtx_en && !prev_en) begin
        if (gap_armed) chk("ipg_gap_ok", 32'((t - fall_t) / 8 >= min_gap), 32'd1);
        cur_mode = (exp_mode_q.size() != 0) ? exp_mode_q[0] : 1'b0;
        nrx = 0; have_nib = 0; nib_i = 0; rise_t = t;
        if (chk_lat) begin chk("latency_ns", 32'(t - hs_t), 32'd4); chk_lat = 0; end
      end
      if (gtx_en) begin
        if (cur_mode) chk("ce_1g", 32'(gtx_ce), 32'd1);
        if (gtx_ce) begin
          if (cur_mode) take(gtxd);
          else begin
            chk("nib_hi_zero", 32'(gtxd[7:4]), 32'd0);
            if (nib_i > 0) chk("ce_100m_gap", 32'((t - last_ce_t) / 8), 32'd5);
            last_ce_t = t; nib_i++;
            if (!have_nib) lo = gtxd[3:0];
            else take({gtxd[3:0], lo});
            have_nib = ~have_nib;
          end
        end
      end
      if (!gtx_en && prev_en) begin
        if (exp_len.size() == 0) chk("spurious_frame", 32'd1, 32'd0);
        else begin
          n_exp = exp_len.pop_front();
          uf_e  = exp_uf_q.pop_front();
          void'(exp_mode_q.pop_front());
          chk("frame_len", 32'(nrx), 32'(n_exp));
          chk("en_cycles", 32'((t - rise_t) / 8), 32'(n_exp * (cur_mode ? 1 : 10)));
          chk("underrun", 32'(tx_underrun), 32'(uf_e));
        end
        fall_t = t; min_gap = cur_mode ? 12 : 120; gap_armed = 1; ipg_armed = 1;
      end
      if (prev_busy && !busy && ipg_armed) begin
        chk("ipg_len", 32'((t - fall_t) / 8), 32'(min_gap));
        ipg_armed = 0;
      end
      prev_en = gtx_en; prev_busy = busy;
    end
  end

  // ---------------- driver ----------------
  // len: frame length; cut: bytes offered before valid is dropped (>=len: no abort)
  task automatic send(input int len, input bit m, input int cut, input int tog);
    int n, w;
    n = (cut < len) ? cut : len;
    @(negedge tx_clk); is_1g = m;
    repeat (4) @(negedge tx_clk);
    exp_len.push_back(n); exp_mode_q.push_back(m); exp_uf_q.push_back(cut < len);
    if (cut < len) n_cut++;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge tx_clk);
      if (i == tog) is_1g = ~m;
      s_data = fb[i]; s_valid = 1'b1; s_last = (i == len - 1);
      w = 0;
      while (!s_ready && w < 60) begin @(negedge tx_clk); w++; end
      if (w >= 60) begin chk("hs_timeout", 32'd1, 32'd0); break; end
      @(posedge tx_clk);
      if (i == 0) begin hs_t = $time; chk_lat = 1'b1; end
      exp_bytes.push_back(fb[i]);
    end
    @(negedge tx_clk); s_valid = 1'b0; s_last = 1'b0;
    w = 0;
    while (busy && w < 400) begin @(negedge tx_clk); w++; end
    if (w >= 400) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, cut, w;
    bit m;
    rst_n = 1'b0; is_1g = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    repeat (3) @(negedge tx_clk);
    chk("reset_outs", {20'd0, gtxd, gtx_en, gtx_ce, tx_underrun, busy, s_ready},
        32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) fb[i] = 8'(i);
    send(64, 1'b1, 64, -1);

    fb[0] = 8'hA5; fb[1] = 8'h3C;
    send(2, 1'b0, 2, -1);
    send(2, 1'b0, 2, -1);

    for (int i = 0; i < 8; i++) fb[i] = 8'(8'h10 + i);
    send(6, 1'b0, 6, 3);
    send(8, 1'b1, 8, -1);

    for (int i = 0; i < 20; i++) fb[i] = 8'(8'h80 + i);
    send(20, 1'b1, 10, -1);
    send(20, 1'b0, 7, -1);

    fb[0] = 8'h55;
    send(1, 1'b1, 1, -1);
    send(1, 1'b0, 1, -1);

    for (int k = 0; k < 14; k++) begin
      len = int'($urandom_range(1, 24));
      m   = 1'($urandom_range(0, 1));
      cut = len;
      if (len > 1 && $urandom_range(0, 3) == 0) cut = int'($urandom_range(1, len - 1));
      for (int i = 0; i < len; i++) fb[i] = 8'($urandom);
      send(len, m, cut, -1);
    end

    // reset in the middle of a 100M frame
    mon_off = 1'b1;
    @(negedge tx_clk); is_1g = 1'b0;
    repeat (4) @(negedge tx_clk);
    s_data = 8'h77; s_valid = 1'b1; s_last = 1'b0;
    w = 0;
    while (!gtx_en && w < 20) begin @(negedge tx_clk); w++; end
    chk("rst_frame_started", 32'(gtx_en), 32'd1);
    repeat (7) @(negedge tx_clk);
    #1 rst_n = 1'b0;
    #1 chk("rst_async_outs", {20'd0, gtxd, gtx_en, gtx_ce, tx_underrun, busy, s_ready},
           32'd0);
    s_valid = 1'b0;
    @(negedge tx_clk); rst_n = 1'b1;
    #1 chk("rst_busy", 32'(busy), 32'd0);
    w = 0;
    while (!gtx_ce && w < 20) begin @(negedge tx_clk); w++; end
    chk("rst_first_ce_ok", 32'(w <= 8 && gtx_ce), 32'd1);
    chk("rst_no_underrun", 32'(tx_underrun), 32'd0);
    mon_off = 1'b0;
    for (int i = 0; i < 5; i++) fb[i] = 8'(8'hC0 + i);
    send(5, 1'b1, 5, -1);

    repeat (10) @(negedge tx_clk);
    chk("left_bytes", 32'(exp_bytes.size()), 32'd0);
    chk("left_frames", 32'(exp_len.size()), 32'd0);
    chk("underrun_pulses", 32'(ucnt), 32'(n_cut));
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
